// File: rtl/localbus_master.sv
//==============================================================================
// Module  : localbus_master
// Brief   : Single-outstanding host-to-localbus bridge (ALE / CS / release
//           handshake) with registered outputs. Optional CS ack timeout is
//           enabled by defining LB_TIMEOUT_EN.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module localbus_master #(
  parameter int ALE_CYC     = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        localbus_cs_n,
  output logic        localbus_rd_wr,
  output logic [31:0] localbus_data,
  output logic        localbus_ale,
  input  logic        localbus_ack_n,
  input  logic [31:0] localbus_data_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ALE  = 2'd1,
    S_CS   = 2'd2,
    S_REL  = 2'd3
  } state_t;

  localparam logic [3:0] c_ale_last = 4'(ALE_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rd;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_ale_cnt;

  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_timeout;
  logic        r_cs_n;
  logic        r_rd_wr;
  logic [31:0] r_lb_data;
  logic        r_ale;

  logic        w_hs;
  logic        w_ack;
  logic        w_timeout;
  logic        w_done;
  logic        w_rd_sel;
  logic [31:0] w_addr_sel;

  // r_cmd_ready is only ever high while in IDLE
  assign w_hs       = cmd_valid && r_cmd_ready && (r_state == S_IDLE);
  assign w_ack      = (r_state == S_CS) && !localbus_ack_n;
  assign w_done     = (r_state == S_CS) && (w_ack || w_timeout);
  assign w_rd_sel   = w_hs ? cmd_rd : r_rd;
  assign w_addr_sel = w_hs ? cmd_addr : r_addr;

`ifdef LB_TIMEOUT_EN
  localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYC - 1);
  logic [15:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= 16'd0;
    end else if (r_state != S_CS) begin
      r_to_cnt <= 16'd0;
    end else if (localbus_ack_n) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // Fires on the CS cycle whose idle ack would bring the count to TIMEOUT_CYC
  assign w_timeout = (r_state == S_CS) && localbus_ack_n && (r_to_cnt == c_to_last);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs)                      w_state_nxt = S_ALE;
      S_ALE:   if (r_ale_cnt == c_ale_last)   w_state_nxt = S_CS;
      S_CS:    if (w_ack || w_timeout)        w_state_nxt = S_REL;
      S_REL:   if (localbus_ack_n)            w_state_nxt = S_IDLE;
      default:                                w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd          <= 1'b0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_ale_cnt     <= 4'd0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'd0;
      r_rsp_timeout <= 1'b0;
      r_cs_n        <= 1'b1;
      r_rd_wr       <= 1'b1;
      r_lb_data     <= 32'd0;
      r_ale         <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rd    <= cmd_rd;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      r_ale_cnt   <= (r_state == S_ALE) ? (r_ale_cnt + 4'd1) : 4'd0;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_cs_n      <= (w_state_nxt != S_CS);
      r_ale       <= (w_state_nxt == S_ALE);
      r_rsp_valid <= w_done;
      if (w_done) begin
        r_rsp_rdata   <= (w_ack && r_rd) ? localbus_data_out : 32'd0;
        r_rsp_timeout <= w_timeout;
      end
      case (w_state_nxt)
        S_ALE: begin
          r_rd_wr   <= w_rd_sel;
          r_lb_data <= w_addr_sel;
        end
        S_CS: begin
          r_rd_wr   <= r_rd;
          r_lb_data <= r_rd ? 32'd0 : r_wdata;
        end
        S_REL: begin
          r_rd_wr   <= r_rd;
          r_lb_data <= 32'd0;
        end
        default: begin
          r_rd_wr   <= 1'b1;
          r_lb_data <= 32'd0;
        end
      endcase
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_timeout    = r_rsp_timeout;
  assign localbus_cs_n  = r_cs_n;
  assign localbus_rd_wr = r_rd_wr;
  assign localbus_data  = r_lb_data;
  assign localbus_ale   = r_ale;

endmodule

`default_nettype wire

// File: tb/tb_localbus_master.sv
//==============================================================================
// Module  : tb_localbus_master
// Brief   : Directed self-checking bench for localbus_master (ALE_CYC=2,
//           TIMEOUT_CYC=8; timeout case runs when LB_TIMEOUT_EN is defined).
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_localbus_master;

  localparam int P_ALE = 2;
  localparam int P_TO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        localbus_cs_n;
  logic        localbus_rd_wr;
  logic [31:0] localbus_data;
  logic        localbus_ale;
  logic        localbus_ack_n;
  logic [31:0] localbus_data_out;

  int n_chk = 0;
  int n_err = 0;
  int cyc_no = 0;

  localbus_master #(
    .ALE_CYC     (P_ALE),
    .TIMEOUT_CYC (P_TO)
  ) u_dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_rd            (cmd_rd),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_timeout       (rsp_timeout),
    .localbus_cs_n     (localbus_cs_n),
    .localbus_rd_wr    (localbus_rd_wr),
    .localbus_data     (localbus_data),
    .localbus_ale      (localbus_ale),
    .localbus_ack_n    (localbus_ack_n),
    .localbus_data_out (localbus_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  // ack_at: CS cycle on which the slave acks (0 = ack_n already low from the start)
  task automatic do_txn(input string nm, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] sdata,
                        input int ack_at, input int rel_hold, input int exp_ncs,
                        input logic [31:0] exp_rdata, input logic exp_to);
    int          n_ale = 0, n_cs = 0, n_rsp = 0, n_rel = 0;
    logic        bad_ale = 1'b0, bad_cs = 1'b0, bad_rdy = 1'b0, done = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        to = 1'b0;
    logic [31:0] exp_cs;
    exp_cs            = rd ? 32'd0 : wdata;
    cmd_valid         = 1'b1;
    cmd_rd            = rd;
    cmd_addr          = addr;
    cmd_wdata         = wdata;
    localbus_data_out = sdata;
    localbus_ack_n    = (ack_at == 0) ? 1'b0 : 1'b1;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      step();
      if (cyc == 0) begin
        cmd_valid = 1'b0;
        cmd_rd    = ~rd;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
      end
      if (localbus_ale) begin
        n_ale++;
        if (localbus_data !== addr || localbus_rd_wr !== rd || !localbus_cs_n) bad_ale = 1'b1;
      end
      if (!localbus_cs_n) begin
        n_cs++;
        if (localbus_data !== exp_cs || localbus_rd_wr !== rd || localbus_ale) bad_cs = 1'b1;
        if (ack_at != 0 && n_cs == ack_at) localbus_ack_n = 1'b0;
      end
      if (rsp_valid) begin
        n_rsp++;
        rdata = rsp_rdata;
        to    = rsp_timeout;
      end
      if (n_rsp > 0 && localbus_cs_n && !cmd_ready) begin
        n_rel++;
        if (localbus_rd_wr !== rd) bad_cs = 1'b1;
        if (n_rel >= rel_hold) localbus_ack_n = 1'b1;
      end
      if (cmd_ready) begin
        if (n_rsp > 0) done = 1'b1;
        else           bad_rdy = 1'b1;
      end
    end
    localbus_ack_n = 1'b1;
    check({nm, "_done"},    32'(done),    32'd1);
    check({nm, "_ale_cyc"}, n_ale,        P_ALE);
    check({nm, "_ale_val"}, 32'(bad_ale), 32'd0);
    check({nm, "_cs_cyc"},  n_cs,         exp_ncs);
    check({nm, "_cs_val"},  32'(bad_cs),  32'd0);
    check({nm, "_rdy_low"}, 32'(bad_rdy), 32'd0);
    check({nm, "_rsp_cnt"}, n_rsp,        1);
    check({nm, "_rdata"},   rdata,        exp_rdata);
    check({nm, "_to"},      32'(to),      32'(exp_to));
    check({nm, "_rel_cyc"}, n_rel,        rel_hold);
  endtask

  initial begin
    int          hs, nrsp, n;
    int          hs_edge[2];
    int          rsp_edge[2];
    logic [31:0] rsp_d[2];

    reset = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    localbus_ack_n = 1'b1; localbus_data_out = 32'd0;
    step(); step();
    check("rst_cs_n",  32'(localbus_cs_n),  32'd1);
    check("rst_ale",   32'(localbus_ale),   32'd0);
    check("rst_rd_wr", 32'(localbus_rd_wr), 32'd1);
    check("rst_data",  localbus_data,       32'd0);
    check("rst_ready", 32'(cmd_ready),      32'd0);
    check("rst_rsp_v", 32'(rsp_valid),      32'd0);
    check("rst_rdata", rsp_rdata,           32'd0);
    check("rst_to",    32'(rsp_timeout),    32'd0);
    reset = 1'b0;
    step();
    check("rst_ready_rise", 32'(cmd_ready), 32'd1);

    do_txn("wr",      1'b0, 32'h0000_0010, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 4, 1, 4, 32'd0, 1'b0);
    do_txn("rd",      1'b1, 32'h0000_0020, 32'h9999_9999, 32'h1234_5678, 2, 1, 2, 32'h1234_5678, 1'b0);
    do_txn("early",   1'b1, 32'h0000_0030, 32'h0,         32'h0BAD_CAFE, 0, 1, 1, 32'h0BAD_CAFE, 1'b0);
    do_txn("relhold", 1'b0, 32'h0000_0034, 32'h5555_AAAA, 32'h7777_7777, 1, 5, 1, 32'd0, 1'b0);

    // Back-to-back with cmd_valid held; slave acks whenever CS is low
    hs = 0; nrsp = 0;
    hs_edge = '{0, 0}; rsp_edge = '{0, 0}; rsp_d = '{32'd0, 32'd0};
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h1111_2222;
    localbus_data_out = 32'hCAFE_F00D;
    for (int i = 0; i < 60 && nrsp < 2; i++) begin
      if (cmd_valid && cmd_ready && hs < 2) begin
        hs_edge[hs] = cyc_no + 1;
        hs++;
      end
      step();
      localbus_ack_n = localbus_cs_n;
      if (hs == 1) begin
        cmd_rd = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'd0;
      end else if (hs == 2) begin
        cmd_valid = 1'b0;
      end
      if (rsp_valid && nrsp < 2) begin
        rsp_d[nrsp]    = rsp_rdata;
        rsp_edge[nrsp] = cyc_no;
        nrsp++;
      end
    end
    cmd_valid = 1'b0; localbus_ack_n = 1'b1;
    check("b2b_hs_cnt",  hs,   2);
    check("b2b_rsp_cnt", nrsp, 2);
    check("b2b_rsp1",    rsp_d[0], 32'd0);
    check("b2b_rsp2",    rsp_d[1], 32'hCAFE_F00D);
    check("b2b_rsp1_lat", rsp_edge[0] - hs_edge[0], 3);
    check("b2b_hs2_gap",  hs_edge[1] - rsp_edge[0], 2);
    check("b2b_txn_len",  hs_edge[1] - hs_edge[0],  5);
    step();
    step();

`ifdef LB_TIMEOUT_EN
    do_txn("tmo", 1'b1, 32'h0000_0050, 32'h0, 32'hDEAD_BEEF, 1000, 1, P_TO, 32'd0, 1'b1);
`endif

    // Reset in the 2nd CS cycle
    n = 0;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 32'h60; cmd_wdata = 32'h0F0F_0F0F;
    for (int i = 0; i < 20 && n < 2; i++) begin
      step();
      cmd_valid = 1'b0;
      if (!localbus_cs_n) n++;
    end
    check("rstmid_reach", n, 2);
    reset = 1'b1;
    step();
    check("rstmid_cs_n",  32'(localbus_cs_n), 32'd1);
    check("rstmid_ale",   32'(localbus_ale),  32'd0);
    check("rstmid_rsp_v", 32'(rsp_valid),     32'd0);
    check("rstmid_ready", 32'(cmd_ready),     32'd0);
    reset = 1'b0;
    step();
    check("rstmid_ready_rise", 32'(cmd_ready), 32'd1);
    check("rstmid_rsp_v2",     32'(rsp_valid), 32'd0);
    check("rstmid_cs_n2",      32'(localbus_cs_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/localbus_master.md
LOCALBUS_MASTER -- requirements
Module: localbus_master

Interface
REQ-001 Parameter ALE_CYC, default 2: number of cycles localbus_ale is held high per transaction (legal range 1..15).
REQ-002 Parameter TIMEOUT_CYC, default 256: number of ack-wait cycles before abort (legal range 2..65535).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  host request present.
REQ-006 cmd_ready  output  1  master can accept a request.
REQ-007 cmd_rd  input  1  1 = read, 0 = write.
REQ-008 cmd_addr  input  32  register address.
REQ-009 cmd_wdata  input  32  write data; ignored for reads.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-012 rsp_timeout  output  1  qualifies rsp_valid; 1 = aborted by timeout.
REQ-013 localbus_cs_n  output  1  chip select, active low.
REQ-014 localbus_rd_wr  output  1  1 = read, 0 = write.
REQ-015 localbus_data  output  32  address while ALE is high, write data while CS is low.
REQ-016 localbus_ale  output  1  address latch enable.
REQ-017 localbus_ack_n  input  1  slave acknowledge, active low; wired-OR of all UM responders.
REQ-018 localbus_data_out  input  32  slave read data, valid when ack_n = 0.

Function
REQ-019 FSM states: IDLE, ALE, CS, REL; all outputs are registered.
REQ-020 IDLE: cmd_ready = 1; cs_n = 1, ale = 0, localbus_data = 0.
- A handshake occurs when cmd_valid & cmd_ready.
- On handshake, latch cmd_rd, cmd_addr and cmd_wdata, then go to ALE.
REQ-021 ALE: ale = 1, localbus_data = addr, cs_n = 1, rd_wr = latched rd.
- Stay for exactly ALE_CYC cycles, then go to CS.
REQ-022 CS: ale = 0, cs_n = 0, rd_wr = latched rd.
- localbus_data = wdata on a write, 0 on a read.
- Timeout counter increments on each cycle ack_n is sampled 1.
REQ-023 CS, ack_n sampled 0: capture localbus_data_out (reads only) and go to REL.
REQ-024 REL, first cycle: cs_n = 1, rsp_valid = 1 for exactly one cycle, rsp_rdata = captured value.
- Stay in REL until ack_n is sampled 1, then go to IDLE.
REQ-025 cmd_ready = 0 in ALE, CS and REL, so only one transaction is outstanding.
- A cmd_valid presented during a transaction is held off and not lost.
REQ-026 Minimum transaction length: ALE_CYC + 1 (CS) + 1 (REL) + 1 (IDLE) cycles.
- Back-to-back commands therefore have at least one IDLE cycle between them.
REQ-027 cmd_* inputs are sampled only on the handshake cycle; later changes have no effect.
REQ-028 ack_n = 0 seen while in IDLE or ALE is ignored.
REQ-029 If ack_n = 0 already on the first CS cycle, the transaction completes with one CS cycle.

Reset
REQ-030 Reset values: state = IDLE, cs_n = 1, ale = 0, rd_wr = 1, localbus_data = 0, cmd_ready = 0 during reset, rsp_valid = 0, rsp_rdata = 0, rsp_timeout = 0, timeout counter = 0.
REQ-031 Reset asserted mid-transaction:
- The next cycle cs_n = 1 and ale = 0.
- No rsp_valid is issued for the aborted transaction.
REQ-032 cmd_ready rises on the first cycle after reset deasserts.

Configuration
REQ-033 Macro LB_TIMEOUT_EN.
- Defined: when the CS timeout counter reaches TIMEOUT_CYC, go to REL with rsp_valid = 1, rsp_timeout = 1, rsp_rdata = 0.
- Undefined: no counter is built, CS waits indefinitely, and rsp_timeout is tied to 0.

Verification
REQ-034 Write addr 0x0000_0010, data 0xA5A5_5A5A, slave acks 3 cycles into CS.
- Required: ale high 2 cycles with data = 0x10.
- Required: cs_n low 4 cycles with data = 0xA5A5_5A5A and rd_wr = 0.
- Required: one rsp_valid pulse with rsp_timeout = 0.
REQ-035 Read addr 0x0000_0020, slave returns 0x1234_5678 with ack_n.
- Required: rsp_rdata = 0x1234_5678 and rd_wr = 1 throughout.
REQ-036 Two commands with cmd_valid held high.
- Required: second handshake occurs only after REL -> IDLE; both responses delivered in order.
REQ-037 With LB_TIMEOUT_EN defined, TIMEOUT_CYC = 8, slave never acks.
- Required: rsp_valid with rsp_timeout = 1, rsp_rdata = 0, after 8 CS cycles.
REQ-038 Reset asserted in the 2nd CS cycle.
- Required: cs_n = 1 the next cycle, no rsp_valid, cmd_ready = 1 the first cycle after reset.
REQ-039 Slave holds ack_n low 5 cycles after acknowledging.
- Required: master stays in REL with cmd_ready = 0 until ack_n returns high.
